// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and result width.
package seq_div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_t;

    localparam int DIV_WIDTH = 32;

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift {rem, quo} left and try to subtract the divisor.
module seq_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};

    // rem < divisor is invariant, so the top bit of the 33-bit difference is the borrow.
    always_comb begin
        rem_nxt = shifted[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_nxt = diff[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle signed/unsigned divider answering the EX-stage divide handshake.
// start_i is held by the requester until ready_o; result_o = {remainder, quotient}.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic             sgn_mode;
    logic             neg_a;
    logic             neg_b;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign a_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign b_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // Sign fix-up applied to the final step's output so DONE is entered with the answer.
    assign q_fix = (sgn_mode && (neg_a ^ neg_b)) ? -quo_nxt : quo_nxt;
    assign r_fix = (sgn_mode && neg_a) ? -rem_nxt : rem_nxt;

    seq_div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (divisor),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            sgn_mode <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                DIV_FREE: begin
                    if (start_i && !annul_i) begin
                        sgn_mode <= signed_div_i;
                        neg_a    <= signed_div_i & opdata1_i[WIDTH-1];
                        neg_b    <= signed_div_i & opdata2_i[WIDTH-1];
                        quo      <= a_abs;
                        divisor  <= b_abs;
                        rem      <= '0;
                        cnt      <= '0;
                        state    <= (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                    end
                end
                DIV_BYZERO: begin
                    if (annul_i) begin
                        state <= DIV_FREE;
                    end else begin
                        state    <= DIV_END;
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end
                DIV_ON: begin
                    if (annul_i) begin
                        state <= DIV_FREE;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_STEP) begin
                            state    <= DIV_END;
                            result_o <= {r_fix, q_fix};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                DIV_END: begin
                    // Holding start_i keeps the result; a new divide needs start_i low first.
                    if (!start_i) begin
                        state    <= DIV_FREE;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed handshake scenarios plus randomized divides.
module tb_seq_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int n_cmp = 0;
    int n_err = 0;

    seq_div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division, remainder takes the dividend's sign.
    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'h0) return 64'h0;
        if (!sg) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        q = sa / sb;
        r = sa % sb;
        return {r, q};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a request and waits (bounded) for ready; lat = edges from capture edge (1) to ready, 0 on timeout.
    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [63:0] res);
        signed_div = sg;
        op1 = a;
        op2 = b;
        start = 1'b1;
        lat = 0;
        res = '0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (ready === 1'b1) begin
                lat = i;
                res = result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        annul = 1'b0;
        signed_div = 1'b0;
        op1 = '0;
        op2 = '0;
        tick();
        tick();
        n_cmp++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 0", ready);
        end
        n_cmp++;
        if (result !== 64'h0) begin
            n_err++;
            $display("FAIL reset_result: got %h want 0", result);
        end
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        int lat;
        logic [63:0] res;
        run_div(1'b0, 32'd100, 32'd7, lat, res);
        n_cmp++;
        if (lat != 33) begin
            n_err++;
            $display("FAIL unsigned_latency: got %0d want 33", lat);
        end
        n_cmp++;
        if (res !== {32'd2, 32'd14}) begin
            n_err++;
            $display("FAIL unsigned_100_7: got %h want %h", res, {32'd2, 32'd14});
        end
        start = 1'b0;
        tick();
        n_cmp++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            n_err++;
            $display("FAIL unsigned_drop: got ready=%b result=%h want 0/0", ready, result);
        end
    endtask

    task automatic test_signed();
        int lat;
        logic [63:0] res;
        logic [31:0] a_tab [3] = '{32'hFFFF_FFF9, 32'h0000_0007, 32'h8000_0000};
        logic [31:0] b_tab [3] = '{32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [63:0] e_tab [3] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD},
                                   {32'h0000_0001, 32'hFFFF_FFFD},
                                   {32'h0000_0000, 32'h8000_0000}};
        for (int i = 0; i < 3; i++) begin
            run_div(1'b1, a_tab[i], b_tab[i], lat, res);
            n_cmp++;
            if (lat != 33 || res !== e_tab[i]) begin
                n_err++;
                $display("FAIL signed_%0d: got lat=%0d res=%h want lat=33 res=%h", i, lat, res, e_tab[i]);
            end
            start = 1'b0;
            tick();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic [63:0] res;
        run_div(1'b1, $urandom, 32'h0, lat, res);
        n_cmp++;
        if (lat != 2 || res !== 64'h0) begin
            n_err++;
            $display("FAIL div_zero: got lat=%0d res=%h want lat=2 res=0", lat, res);
        end
        start = 1'b0;
        tick();
        n_cmp++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL div_zero_drop: got ready=%b want 0", ready);
        end
    endtask

    task automatic test_annul();
        int lat;
        int seen;
        logic [63:0] res;
        signed_div = 1'b0;
        op1 = $urandom;
        op2 = 32'd3;
        start = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) tick();
        annul = 1'b1;
        start = 1'b0;
        tick();
        annul = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL annul_no_ready: got %0d ready cycles want 0", seen);
        end
        run_div(1'b0, 32'hFFFF_FFFF, 32'h10, lat, res);
        n_cmp++;
        if (lat != 33 || res !== {32'h0000_000F, 32'h0FFF_FFFF}) begin
            n_err++;
            $display("FAIL annul_next: got lat=%0d res=%h want lat=33 res=%h",
                     lat, res, {32'h0000_000F, 32'h0FFF_FFFF});
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_mid_change();
        int lat;
        int bad;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        logic [63:0] res;
        a = $urandom;
        b = $urandom >> $urandom_range(4, 28);
        if (b == 0) b = 32'd9;
        exp = model(1'b1, a, b);
        signed_div = 1'b1;
        op1 = a;
        op2 = b;
        start = 1'b1;
        tick();
        lat = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            lat++;
        end
        op1 = ~a;
        op2 = b + 32'd5;
        signed_div = 1'b0;
        res = '0;
        for (int i = 0; i < 50 && ready !== 1'b1; i++) begin
            tick();
            lat++;
        end
        if (ready === 1'b1) res = result;
        else lat = 0;
        n_cmp++;
        if (lat != 33 || res !== exp) begin
            n_err++;
            $display("FAIL mid_change: got lat=%0d res=%h want lat=33 res=%h", lat, res, exp);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ready !== 1'b1 || result !== exp) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL hold_stable: got %0d unstable cycles want 0", bad);
        end
        start = 1'b0;
        tick();
        n_cmp++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            n_err++;
            $display("FAIL hold_drop: got ready=%b result=%h want 0/0", ready, result);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        logic [63:0] res;
        signed_div = 1'b0;
        op1 = 32'd100;
        op2 = 32'd7;
        start = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            n_err++;
            $display("FAIL rst_busy: got ready=%b result=%h want 0/0", ready, result);
        end
        start = 1'b0;
        #1 rst = 1'b0;
        tick();
        // Reset while DONE holds a result must clear the outputs without waiting for an edge.
        run_div(1'b0, 32'd1000, 32'd3, lat, res);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (lat != 33 || ready !== 1'b0 || result !== 64'h0) begin
            n_err++;
            $display("FAIL rst_done: got lat=%0d ready=%b result=%h want 33/0/0", lat, ready, result);
        end
        start = 1'b0;
        #1 rst = 1'b0;
        tick();
        run_div(1'b0, 32'd100, 32'd7, lat, res);
        n_cmp++;
        if (lat != 33 || res !== {32'd2, 32'd14}) begin
            n_err++;
            $display("FAIL rst_recover: got lat=%0d res=%h want lat=33 res=%h", lat, res, {32'd2, 32'd14});
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int lat;
        int exp_lat;
        logic sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        logic [63:0] res;
        for (int n = 0; n < 24; n++) begin
            sg = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 15);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            exp = model(sg, a, b);
            exp_lat = (b == 32'h0) ? 2 : 33;
            run_div(sg, a, b, lat, res);
            n_cmp++;
            if (lat != exp_lat || res !== exp) begin
                n_err++;
                $display("FAIL random_%0d: sg=%b a=%h b=%h got lat=%0d res=%h want lat=%0d res=%h",
                         n, sg, a, b, lat, res, exp_lat, exp);
            end
            start = 1'b0;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_mid_change();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
